// File: rtl/serial_shift_unit_if.sv
// Start/busy/done bus between the EX stage and the serial shifter.
// Inputs carry the _i suffix and results the _o suffix, as seen from the shifter.
interface serial_shift_unit_if #(
   parameter int DATA_WIDTH = 32
);
   logic                  start_i;
   logic [1:0]            op_i;
   logic [DATA_WIDTH-1:0] data_i;
   logic [31:0]           shamt_i;
   logic                  busy_o;
   logic                  done_o;
   logic [DATA_WIDTH-1:0] result_o;
   logic                  shamt_err_o;

   modport master (
      output start_i, op_i, data_i, shamt_i,
      input  busy_o, done_o, result_o, shamt_err_o
   );

   modport slave (
      input  start_i, op_i, data_i, shamt_i,
      output busy_o, done_o, result_o, shamt_err_o
   );
endinterface

// File: rtl/serial_shift_unit.sv
// Multi-cycle SLL/SRL/SRA shifter with start/busy/done handshake.
// Define SERIAL_SHIFT_UNIT_FAST_EN to step by 4 bits while count >= 4.
module serial_shift_unit #(
   parameter int DATA_WIDTH  = 32,
   parameter int SHAMT_WIDTH = 5
) (
   input  logic           clk_i,
   input  logic           rst_i,
   serial_shift_unit_if.slave bus
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } state_t;

   state_t                 state;
   logic [DATA_WIDTH-1:0]  work;
   logic [DATA_WIDTH-1:0]  work_nxt;
   logic [SHAMT_WIDTH-1:0] count;
   logic [SHAMT_WIDTH-1:0] step;
   logic [SHAMT_WIDTH-1:0] shamt_lo;
   logic [1:0]             op;
   logic                   err;
   logic                   err_in;

   assign shamt_lo = bus.shamt_i[SHAMT_WIDTH-1:0];
   assign err_in   = |bus.shamt_i[31:SHAMT_WIDTH];

   always_comb begin
`ifdef SERIAL_SHIFT_UNIT_FAST_EN
      step = (count >= SHAMT_WIDTH'(4)) ? SHAMT_WIDTH'(4)
                                        : SHAMT_WIDTH'(1);
`else
      step = SHAMT_WIDTH'(1);
`endif
      // SRA on the working value keeps the latched operand's sign bit
      case (op)
         2'b01:   work_nxt = work >> step;
         2'b10:   work_nxt = $signed(work) >>> step;
         default: work_nxt = work << step;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state           <= IDLE;
         work            <= '0;
         count           <= '0;
         op              <= '0;
         err             <= 1'b0;
         bus.busy_o      <= 1'b0;
         bus.done_o      <= 1'b0;
         bus.result_o    <= '0;
         bus.shamt_err_o <= 1'b0;
      end else begin
         bus.done_o      <= 1'b0;
         bus.shamt_err_o <= 1'b0;
         case (state)
            IDLE: begin
               if (bus.start_i) begin
                  work       <= bus.data_i;
                  op         <= bus.op_i;
                  count      <= shamt_lo;
                  err        <= err_in;
                  bus.busy_o <= 1'b1;
                  if (shamt_lo == '0) begin
                     state           <= DONE;
                     bus.result_o    <= bus.data_i;
                     bus.done_o      <= 1'b1;
                     bus.shamt_err_o <= err_in;
                  end else begin
                     state <= SHIFT;
                  end
               end
            end
            SHIFT: begin
               work  <= work_nxt;
               count <= count - step;
               // outputs are registered, so load them on the final step
               if (count == step) begin
                  state           <= DONE;
                  bus.result_o    <= work_nxt;
                  bus.done_o      <= 1'b1;
                  bus.shamt_err_o <= err;
               end
            end
            DONE: begin
               state      <= IDLE;
               bus.busy_o <= 1'b0;
            end
            default: begin
               state      <= IDLE;
               bus.busy_o <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_serial_shift_unit.sv
// Scoreboard bench for serial_shift_unit: directed cases, abort, back-to-back, random.
// Honors SERIAL_SHIFT_UNIT_FAST_EN for expected latency.
module tb_serial_shift_unit;

   typedef struct {
      logic [31:0] res;
      logic        err;
      int          lat;
   } exp_t;

   logic clk;
   logic rst;
   int   vectors;
   int   miscompares;
   exp_t sb[$];

   serial_shift_unit_if bus ();

   serial_shift_unit dut (
      .clk_i (clk),
      .rst_i (rst),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [31:0] model(logic [1:0] op, logic [31:0] d,
                                         logic [31:0] sh);
      int n;
      n = int'(sh[4:0]);
      case (op)
         2'b01:   return d >> n;
         2'b10:   return $signed(d) >>> n;
         default: return d << n;
      endcase
   endfunction

   function automatic int exp_lat(logic [31:0] sh);
      int n;
      n = int'(sh[4:0]);
`ifdef SERIAL_SHIFT_UNIT_FAST_EN
      return n / 4 + n % 4 + 1;
`else
      return n + 1;
`endif
   endfunction

   // Call at a negedge in IDLE; returns at the negedge of the cycle after start.
   task automatic issue(input logic [1:0] op, input logic [31:0] d,
                        input logic [31:0] sh, input bit track);
      exp_t e;
      bus.start_i = 1'b1;
      bus.op_i    = op;
      bus.data_i  = d;
      bus.shamt_i = sh;
      if (track) begin
         e.res = model(op, d, sh);
         e.err = |sh[31:5];
         e.lat = exp_lat(sh);
         sb.push_back(e);
      end
      @(negedge clk);
      bus.start_i = 1'b0;
      bus.op_i    = 2'($urandom);
      bus.data_i  = $urandom;
      bus.shamt_i = $urandom;
   endtask

   // Bounded wait for done_o; pops the matching expectation.
   task automatic collect(output int lat, output exp_t e);
      lat = 1;
      while (bus.done_o !== 1'b1 && lat < 100) begin
         @(negedge clk);
         lat++;
      end
      if (sb.size() > 0) begin
         e = sb.pop_front();
      end else begin
         e.res = 32'hxxxx_xxxx;
         e.err = 1'bx;
         e.lat = -1;
      end
   endtask

   task automatic test_reset();
      rst         = 1'b1;
      bus.start_i = 1'b0;
      bus.op_i    = 2'b00;
      bus.data_i  = '0;
      bus.shamt_i = '0;
      repeat (3) @(negedge clk);
      vectors++;
      if ({bus.busy_o, bus.done_o, bus.shamt_err_o, bus.result_o} !== 35'd0) begin
         miscompares++;
         $display("FAIL reset: busy=%b done=%b err=%b res=%h, want all 0",
                  bus.busy_o, bus.done_o, bus.shamt_err_o, bus.result_o);
      end
      rst = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_directed(input string name, input logic [1:0] op,
                                input logic [31:0] d, input logic [31:0] sh,
                                input logic [31:0] want, input logic want_err,
                                input int want_lat);
      int   lat;
      exp_t e;
      issue(op, d, sh, 1'b1);
      collect(lat, e);
      vectors++;
      if (lat !== e.lat || lat !== want_lat) begin
         miscompares++;
         $display("FAIL %s latency: got %0d want %0d", name, lat, want_lat);
      end
      vectors++;
      if (bus.result_o !== e.res || bus.result_o !== want) begin
         miscompares++;
         $display("FAIL %s result: got %h want %h", name, bus.result_o, want);
      end
      vectors++;
      if (bus.shamt_err_o !== e.err || bus.shamt_err_o !== want_err) begin
         miscompares++;
         $display("FAIL %s shamt_err: got %b want %b", name,
                  bus.shamt_err_o, want_err);
      end
      vectors++;
      if (bus.busy_o !== 1'b1) begin
         miscompares++;
         $display("FAIL %s busy_at_done: got %b want 1", name, bus.busy_o);
      end
      @(negedge clk);
      vectors++;
      if (bus.busy_o !== 1'b0 || bus.done_o !== 1'b0) begin
         miscompares++;
         $display("FAIL %s idle_after: busy=%b done=%b want 0 0", name,
                  bus.busy_o, bus.done_o);
      end
   endtask

   task automatic test_abort();
      int   lat;
      exp_t e;
      issue(2'b00, 32'h0000_0001, 32'd10, 1'b0);
      for (int i = 1; i <= 5; i++) begin
         bus.start_i = (i == 3 || i == 5);
         vectors++;
         if (bus.done_o !== 1'b0 || bus.busy_o !== 1'b1) begin
            miscompares++;
            $display("FAIL abort cycle %0d: done=%b busy=%b want 0 1", i,
                     bus.done_o, bus.busy_o);
         end
         @(negedge clk);
      end
      bus.start_i = 1'b0;
      rst         = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      vectors++;
      if (bus.busy_o !== 1'b0 || bus.done_o !== 1'b0 || bus.result_o !== 32'h0) begin
         miscompares++;
         $display("FAIL abort reset: busy=%b done=%b res=%h want 0 0 0",
                  bus.busy_o, bus.done_o, bus.result_o);
      end
      issue(2'b00, 32'h0000_0003, 32'd2, 1'b1);
      collect(lat, e);
      vectors++;
      if (lat !== e.lat || bus.result_o !== e.res || bus.result_o !== 32'hC) begin
         miscompares++;
         $display("FAIL abort restart: lat=%0d res=%h want lat=%0d res=%h",
                  lat, bus.result_o, e.lat, e.res);
      end
      @(negedge clk);
   endtask

   task automatic test_back_to_back();
      int   lat;
      exp_t e;
      issue(2'b00, 32'h0000_0001, 32'd1, 1'b1);
      collect(lat, e);
      vectors++;
      if (lat !== e.lat || bus.result_o !== 32'h2) begin
         miscompares++;
         $display("FAIL b2b first: lat=%0d res=%h want lat=%0d res=00000002",
                  lat, bus.result_o, e.lat);
      end
      @(negedge clk);
      vectors++;
      if (bus.done_o !== 1'b0) begin
         miscompares++;
         $display("FAIL b2b done_width1: done=%b want 0", bus.done_o);
      end
      issue(2'b10, 32'h8000_0000, 32'd2, 1'b1);
      collect(lat, e);
      vectors++;
      if (lat !== e.lat || bus.result_o !== 32'hE000_0000) begin
         miscompares++;
         $display("FAIL b2b second: lat=%0d res=%h want lat=%0d res=e0000000",
                  lat, bus.result_o, e.lat);
      end
      @(negedge clk);
      vectors++;
      if (bus.done_o !== 1'b0) begin
         miscompares++;
         $display("FAIL b2b done_width2: done=%b want 0", bus.done_o);
      end
   endtask

   task automatic test_random();
      int          lat;
      exp_t        e;
      logic [31:0] sh;
      for (int i = 0; i < 24; i++) begin
         sh = ($urandom_range(0, 3) == 0) ? $urandom : 32'($urandom_range(0, 31));
         issue(2'($urandom_range(0, 3)), $urandom, sh, 1'b1);
         collect(lat, e);
         vectors++;
         if (lat !== e.lat || bus.result_o !== e.res || bus.shamt_err_o !== e.err) begin
            miscompares++;
            $display("FAIL random %0d: lat=%0d res=%h err=%b want lat=%0d res=%h err=%b",
                     i, lat, bus.result_o, bus.shamt_err_o, e.lat, e.res, e.err);
         end
         @(negedge clk);
      end
   endtask

   initial begin
      vectors     = 0;
      miscompares = 0;
      rst         = 1'b1;
      @(negedge clk);
      test_reset();
      test_directed("sll4", 2'b00, 32'h0000_0001, 32'h0000_0004,
                    32'h0000_0010, 1'b0, exp_lat(32'd4));
      test_directed("sra31", 2'b10, 32'h8000_0000, 32'd31,
                    32'hFFFF_FFFF, 1'b0, exp_lat(32'd31));
      test_directed("srl0", 2'b01, 32'hDEAD_BEEF, 32'd0,
                    32'hDEAD_BEEF, 1'b0, 1);
      test_directed("srl_err", 2'b01, 32'hF000_0000, 32'h0000_0024,
                    32'h0F00_0000, 1'b1, exp_lat(32'd4));
      test_directed("rsvd_sll", 2'b11, 32'h0000_00F0, 32'd8,
                    32'h0000_F000, 1'b0, exp_lat(32'd8));
      test_abort();
      test_back_to_back();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
